// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage and its alignment helper.
package mem_stage_pkg;

    typedef logic [31:0] data_t;
    typedef logic [4:0]  reg_addr_t;
    typedef logic        enable_t;
    typedef logic [1:0]  wb_data_sel_t;

    // Load and store share encodings: F3_B is LB/SB, F3_H is LH/SH, F3_W is LW/SW.
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } mem_funct3_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    function automatic data_t ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic data_t ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store replication and strobes, load extraction
// and extension, and the misalignment check for a given size and byte offset.
module mem_align
    import mem_stage_pkg::*;
(
    input  mem_funct3_t funct3,
    input  logic [1:0]  offset,
    input  logic        we,
    input  data_t       store_data,
    input  data_t       rdata,
    output data_t       wdata,
    output logic [3:0]  wstrb,
    output data_t       load_data,
    output logic        misaligned
);

    data_t      byte_lane_s;
    data_t      half_lane_s;
    logic [3:0] strb_s;

    assign byte_lane_s = rdata >> {offset, 3'b000};
    assign half_lane_s = rdata >> {offset[1], 4'b0000};

    // Size decode drives every output; loads never assert a strobe.
    always_comb begin
        wdata      = store_data;
        strb_s     = STRB_NONE;
        load_data  = rdata;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                wdata     = {4{store_data[7:0]}};
                strb_s    = STRB_BYTE << offset;
                load_data = ext8(byte_lane_s[7:0], funct3 == F3_B);
            end
            F3_H, F3_HU: begin
                misaligned = offset[0];
                wdata      = {2{store_data[15:0]}};
                strb_s     = STRB_HALF << offset;
                load_data  = ext16(half_lane_s[15:0], funct3 == F3_H);
            end
            F3_W: begin
                misaligned = |offset;
                wdata      = store_data;
                strb_s     = STRB_WORD;
                load_data  = rdata;
            end
            default: begin
                misaligned = 1'b0;
                strb_s     = STRB_NONE;
            end
        endcase
        if (we) begin
            wstrb = strb_s;
        end else begin
            wstrb = STRB_NONE;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores on a req/ready bus, stalls upstream
// while an access is outstanding and presents results or bubbles to MEM2WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  reg_addr_t    rd_i,
    input  data_t        alu_result_i,
    input  data_t        store_data_i,
    input  data_t        pc_next_i,
    input  enable_t      mem_read_c_i,
    input  enable_t      mem_write_c_i,
    input  mem_funct3_t  mem_funct3_c_i,
    input  enable_t      reg_write_c_i,
    input  wb_data_sel_t wb_data_sel_c_i,
    output logic         dmem_req_o,
    output logic         dmem_we_o,
    output data_t        dmem_addr_o,
    output data_t        dmem_wdata_o,
    output logic [3:0]   dmem_wstrb_o,
    input  logic         dmem_ready_i,
    input  data_t        dmem_rdata_i,
    output reg_addr_t    rd_o,
    output data_t        alu_result_o,
    output data_t        pc_next_o,
    output data_t        mem_read_data_o,
    output enable_t      reg_write_c_o,
    output wb_data_sel_t wb_data_sel_c_o,
    output logic         stall_o,
    output logic         misalign_o,
    output logic         bus_err_o
);

    mem_state_t   state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    data_t        addr_r, wdata_r, pc_r;
    logic [3:0]   wstrb_r;
    logic         we_r, rw_r;
    mem_funct3_t  f3_r;
    reg_addr_t    rd_r;
    wb_data_sel_t wbsel_r;

    logic         access_s, we_in_s, latch_s, in_wait_s;
    mem_funct3_t  al_f3_s;
    logic [1:0]   al_off_s;
    data_t        al_wdata_s, al_load_s;
    logic [3:0]   al_wstrb_s;
    logic         al_mis_s;

    // A read+write combination is treated as a read.
    assign access_s  = valid_i & (mem_read_c_i | mem_write_c_i);
    assign we_in_s   = mem_write_c_i & ~mem_read_c_i;
    assign in_wait_s = (state_r == ST_WAIT);
    assign al_f3_s   = in_wait_s ? f3_r : mem_funct3_c_i;
    assign al_off_s  = in_wait_s ? addr_r[1:0] : alu_result_i[1:0];

    mem_align u_align (
        .funct3     (al_f3_s),
        .offset     (al_off_s),
        .we         (we_in_s),
        .store_data (store_data_i),
        .rdata      (dmem_rdata_i),
        .wdata      (al_wdata_s),
        .wstrb      (al_wstrb_s),
        .load_data  (al_load_s),
        .misaligned (al_mis_s)
    );

    // Next-state, bus drive and MEM2WB outputs; control outputs are forced low in reset.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = '0;
        latch_s         = 1'b0;
        dmem_req_o      = 1'b0;
        dmem_we_o       = we_in_s;
        dmem_addr_o     = {alu_result_i[31:2], 2'b00};
        dmem_wdata_o    = al_wdata_s;
        dmem_wstrb_o    = al_wstrb_s;
        rd_o            = rd_i;
        alu_result_o    = alu_result_i;
        pc_next_o       = pc_next_i;
        mem_read_data_o = al_load_s;
        reg_write_c_o   = 1'b0;
        wb_data_sel_c_o = wb_data_sel_c_i;
        stall_o         = 1'b0;
        misalign_o      = 1'b0;
        bus_err_o       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    if (al_mis_s) begin
                        misalign_o = 1'b1;
                    end else begin
                        dmem_req_o = 1'b1;
                        latch_s    = 1'b1;
                        if (dmem_ready_i) begin
                            reg_write_c_o = reg_write_c_i & ~we_in_s;
                        end else begin
                            state_nxt_s = ST_WAIT;
                            stall_o     = 1'b1;
                        end
                    end
                end else begin
                    reg_write_c_o = reg_write_c_i & valid_i;
                end
            end
            ST_WAIT: begin
                dmem_req_o      = 1'b1;
                dmem_we_o       = we_r;
                dmem_addr_o     = {addr_r[31:2], 2'b00};
                dmem_wdata_o    = wdata_r;
                dmem_wstrb_o    = wstrb_r;
                rd_o            = rd_r;
                alu_result_o    = addr_r;
                pc_next_o       = pc_r;
                wb_data_sel_c_o = wbsel_r;
                if (dmem_ready_i) begin
                    reg_write_c_o = rw_r;
                    state_nxt_s   = ST_IDLE;
                end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES)) begin
                    dmem_req_o  = 1'b0;
                    bus_err_o   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    stall_o   = 1'b1;
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        dmem_req_o    = dmem_req_o & ~rst;
        stall_o       = stall_o & ~rst;
        reg_write_c_o = reg_write_c_o & ~rst;
        misalign_o    = misalign_o & ~rst;
        bus_err_o     = bus_err_o & ~rst;
    end

    // State, wait counter and the request snapshot held across WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            pc_r    <= '0;
            wstrb_r <= STRB_NONE;
            we_r    <= 1'b0;
            rw_r    <= 1'b0;
            f3_r    <= F3_B;
            rd_r    <= '0;
            wbsel_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (latch_s) begin
                addr_r  <= alu_result_i;
                wdata_r <= al_wdata_s;
                pc_r    <= pc_next_i;
                wstrb_r <= al_wstrb_s;
                we_r    <= we_in_s;
                rw_r    <= reg_write_c_i & ~we_in_s;
                f3_r    <= mem_funct3_c_i;
                rd_r    <= rd_i;
                wbsel_r <= wb_data_sel_c_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage: a driver issues instructions and
// pushes expected responses; a monitor pops and compares whenever stall_o is low.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO    = 4;
    localparam int NEVER = -1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_i = 1'b0;
    reg_addr_t rd_i = '0;
    data_t alu_result_i = '0, store_data_i = '0, pc_next_i = '0;
    logic mem_read_c_i = 1'b0, mem_write_c_i = 1'b0, reg_write_c_i = 1'b0;
    mem_funct3_t mem_funct3_c_i = F3_W;
    wb_data_sel_t wb_data_sel_c_i = '0;
    logic dmem_ready_i = 1'b0;
    data_t dmem_rdata_i = '0;
    logic dmem_req_o, dmem_we_o, stall_o, misalign_o, bus_err_o, reg_write_c_o;
    data_t dmem_addr_o, dmem_wdata_o, alu_result_o, pc_next_o, mem_read_data_o;
    logic [3:0] dmem_wstrb_o;
    reg_addr_t rd_o;
    wb_data_sel_t wb_data_sel_c_o;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .rd_i(rd_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .pc_next_i(pc_next_i),
        .mem_read_c_i(mem_read_c_i), .mem_write_c_i(mem_write_c_i),
        .mem_funct3_c_i(mem_funct3_c_i), .reg_write_c_i(reg_write_c_i),
        .wb_data_sel_c_i(wb_data_sel_c_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i), .rd_o(rd_o),
        .alu_result_o(alu_result_o), .pc_next_o(pc_next_o), .mem_read_data_o(mem_read_data_o),
        .reg_write_c_o(reg_write_c_o), .wb_data_sel_c_o(wb_data_sel_c_o), .stall_o(stall_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic valid, rd_en, wr_en, rw;
        mem_funct3_t f3;
        data_t alu, sd, rdata, pc;
        int lat;
        wb_data_sel_t wbsel;
        reg_addr_t rd;
    } instr_t;

    typedef struct {
        logic bus, misal, err, we, is_load, rw;
        int stall;
        reg_addr_t rd;
        data_t alu, pc, ld, addr, wdata;
        logic [3:0] wstrb;
        wb_data_sel_t wbsel;
    } exp_t;

    int n_chk = 0;
    int n_pass = 0;
    exp_t q[$];
    exp_t mon_e;
    bit mon_en = 1'b0;
    int stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: derives the response from sizes, offsets and latencies.
    function automatic exp_t model(input instr_t s);
        exp_t e;
        int size, o;
        logic acc, sgn;
        data_t v;
        acc  = s.valid & (s.rd_en | s.wr_en);
        size = int'(s.f3[1:0]);
        sgn  = ~s.f3[2];
        o    = int'(s.alu % 4);
        e = '{bus: 0, misal: 0, err: 0, we: 0, is_load: 0, rw: s.rw & s.valid, stall: 0,
              rd: s.rd, alu: s.alu, pc: s.pc, ld: 0, addr: 0, wdata: 0, wstrb: 0, wbsel: s.wbsel};
        if (acc) begin
            e.rw = 1'b0;
            if ((size == 1 && (o % 2) == 1) || (size == 2 && o != 0)) begin
                e.misal = 1'b1;
            end else begin
                e.bus     = 1'b1;
                e.is_load = s.rd_en;
                e.we      = ~s.rd_en;
                e.addr    = s.alu - data_t'(o);
                if (size == 0) e.wdata = (s.sd & 32'hFF) * 32'h0101_0101;
                else if (size == 1) e.wdata = (s.sd & 32'hFFFF) * 32'h0001_0001;
                else e.wdata = s.sd;
                if (!e.we) e.wstrb = 4'b0000;
                else if (size == 0) e.wstrb = 4'(1 << o);
                else if (size == 1) e.wstrb = 4'(3 << o);
                else e.wstrb = 4'b1111;
                if (size == 0) begin
                    v = (s.rdata >> (8 * o)) & 32'hFF;
                    if (sgn && v[7]) v = v | 32'hFFFF_FF00;
                end else if (size == 1) begin
                    v = (s.rdata >> (16 * (o / 2))) & 32'hFFFF;
                    if (sgn && v[15]) v = v | 32'hFFFF_0000;
                end else begin
                    v = s.rdata;
                end
                e.ld = v;
                if (s.lat < 0 || s.lat > TO + 1) begin
                    e.err   = 1'b1;
                    e.stall = TO + 1;
                end else begin
                    e.stall = s.lat;
                    e.rw    = s.rd_en & s.rw;
                end
            end
        end
        return e;
    endfunction

    // Monitor: bus stability during stalls, full comparison when a result is presented.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (stall_o) begin
                stall_cnt++;
                if (q.size() > 0) begin
                    chk("wait_req", dmem_req_o, 1'b1);
                    chk("wait_addr", dmem_addr_o, q[0].addr);
                    chk("wait_we", dmem_we_o, q[0].we);
                    chk("wait_wstrb", dmem_wstrb_o, q[0].wstrb);
                    if (q[0].we) chk("wait_wdata", dmem_wdata_o, q[0].wdata);
                end
            end else if (q.size() == 0) begin
                chk("output_without_stimulus", 32'(q.size()), 32'd1);
            end else begin
                mon_e = q.pop_front();
                chk("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall));
                stall_cnt = 0;
                chk("rd", rd_o, mon_e.rd);
                chk("alu_result", alu_result_o, mon_e.alu);
                chk("pc_next", pc_next_o, mon_e.pc);
                chk("wb_sel", wb_data_sel_c_o, mon_e.wbsel);
                chk("reg_write", reg_write_c_o, mon_e.rw);
                chk("misalign", misalign_o, mon_e.misal);
                chk("bus_err", bus_err_o, mon_e.err);
                if (mon_e.bus && !mon_e.err) begin
                    chk("req", dmem_req_o, 1'b1);
                    chk("we", dmem_we_o, mon_e.we);
                    chk("addr", dmem_addr_o, mon_e.addr);
                    chk("wstrb", dmem_wstrb_o, mon_e.wstrb);
                    if (mon_e.we) chk("wdata", dmem_wdata_o, mon_e.wdata);
                    else chk("load_data", mem_read_data_o, mon_e.ld);
                end else begin
                    chk("no_req", dmem_req_o, 1'b0);
                end
            end
        end
    end

    task automatic apply(input instr_t s, input int k);
        valid_i = s.valid; rd_i = s.rd; alu_result_i = s.alu; store_data_i = s.sd;
        pc_next_i = s.pc; mem_read_c_i = s.rd_en; mem_write_c_i = s.wr_en;
        mem_funct3_c_i = s.f3; reg_write_c_i = s.rw; wb_data_sel_c_i = s.wbsel;
        dmem_rdata_i = s.rdata;
        if (s.valid && (s.rd_en || s.wr_en)) dmem_ready_i = (s.lat == k);
        else dmem_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input instr_t s, input bit no_edge);
        if (!no_edge) begin
            @(posedge clk); #1;
        end
        apply(s, 0);
        q.push_back(model(s));
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk); #1;
            if (!stall_o) return;
            @(posedge clk); #1;
            apply(s, k);
        end
        chk("stall_bound", stall_o, 1'b0);
    endtask

    function automatic instr_t mk(input logic v, input logic r, input logic w, input mem_funct3_t f,
                                  input data_t a, input data_t sd, input data_t rdata,
                                  input int lat, input logic rw);
        instr_t s;
        s = '{valid: v, rd_en: r, wr_en: w, rw: rw, f3: f, alu: a, sd: sd, rdata: rdata,
              pc: $urandom, lat: lat, wbsel: 2'($urandom), rd: 5'($urandom)};
        return s;
    endfunction

    function automatic instr_t rand_instr();
        mem_funct3_t f3s[5];
        int r, kind;
        instr_t s;
        f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        kind = $urandom_range(0, 9);
        r = $urandom_range(0, 9);
        s = mk(($urandom % 8) != 0, kind < 4 || kind == 9, kind >= 4 && kind < 8,
               f3s[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
               (r < 7) ? $urandom_range(0, 3) : (r < 8) ? TO + 1 : (r < 9) ? TO : NEVER,
               1'($urandom));
        return s;
    endfunction

    initial begin
        instr_t s;
        // Outputs held low under reset even with live access inputs.
        @(posedge clk); #1;
        apply(mk(1, 1, 0, F3_W, 32'h100, 32'h0, 32'h1234_5678, 0, 1), 0);
        @(negedge clk);
        chk("rst_req", dmem_req_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_reg_write", reg_write_c_o, 1'b0);
        @(posedge clk); #1;
        apply(mk(1, 1, 0, F3_W, 32'h102, 32'h0, 32'h0, 0, 1), 0);
        @(negedge clk);
        chk("rst_misalign", misalign_o, 1'b0);
        chk("rst_bus_err", bus_err_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        issue(mk(1, 0, 1, F3_W, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1), 1);
        issue(mk(1, 1, 0, F3_B, 32'h103, 32'h0, 32'h80FF_1234, 3, 1), 0);
        issue(mk(1, 1, 0, F3_HU, 32'h102, 32'h0, 32'h8001_0000, 1, 1), 0);
        issue(mk(1, 0, 1, F3_B, 32'h101, 32'h5A, 32'h0, 2, 1), 0);
        issue(mk(1, 1, 0, F3_W, 32'h102, 32'h0, 32'h0, 0, 1), 0);
        issue(mk(1, 1, 0, F3_W, 32'h200, 32'h0, 32'h0, NEVER, 1), 0);
        issue(mk(1, 0, 0, F3_W, 32'h1234, 32'h0, 32'h0, 0, 1), 0);
        issue(mk(1, 1, 0, F3_H, 32'h202, 32'h0, 32'hF00F_0FF0, TO + 1, 1), 0);
        issue(mk(0, 1, 0, F3_W, 32'h300, 32'h0, 32'h0, 0, 1), 0);
        issue(mk(1, 1, 1, F3_BU, 32'h301, 32'h77, 32'hA5C3_E1F0, 1, 1), 0);

        // Reset on the second WAIT cycle: no error pulse, back in IDLE afterwards.
        mon_en = 1'b0;
        s = mk(1, 1, 0, F3_W, 32'h400, 32'h0, 32'h0, NEVER, 1);
        @(posedge clk); #1; apply(s, 0);
        @(posedge clk); #1; apply(s, 1);
        @(negedge clk);
        chk("pre_rst_in_wait", stall_o, 1'b1);
        @(posedge clk); #1; apply(s, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midwait_rst_req", dmem_req_o, 1'b0);
        chk("midwait_rst_stall", stall_o, 1'b0);
        chk("midwait_rst_reg_write", reg_write_c_o, 1'b0);
        chk("midwait_rst_bus_err", bus_err_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        stall_cnt = 0;
        mon_en = 1'b1;
        issue(mk(1, 0, 0, F3_W, 32'h1234, 32'h0, 32'h0, 0, 1), 1);

        for (int i = 0; i < 300; i++) issue(rand_instr(), 0);
        mon_en = 1'b0;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
